elementwise_seq: RTL and testbench

- Command-driven sequencer for the elementwise array.
- Accepts one command: function code, source base, destination base, vector count.
- Streams vectors from the vector buffer through the array and writes the results back.
- Sits between the top-level instruction decoder and the vector buffer / elementwise array pair. One command in flight at a time.

---
 rtl/elementwise_seq.sv | 129 ++++++++++++
 tb/tb_elementwise_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elementwise_seq.sv
// elementwise_seq: command sequencer streaming vectors buffer -> elementwise array -> buffer (optional macro ELEMENTWISE_SEQ_PERF_EN adds perf_cycles).
// Latency: len>0 -> len+1+EW_LAT busy cycles then one done cycle; len==0 -> done in the cycle after accept.
// Backpressure: cmd_ready only in IDLE, one command in flight; no stall path once a command runs.
module elementwise_seq #(
    parameter int AW     = 8,
    parameter int LW     = 8,
    parameter int EW_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_func,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [LW-1:0] cmd_len,
    output logic          buf_rd_en,
    output logic [AW-1:0] buf_rd_addr,
    output logic          ew_en,
    output logic [3:0]    ew_func,
    output logic          buf_wr_en,
    output logic [AW-1:0] buf_wr_addr,
    output logic          busy,
    output logic          done
`ifdef ELEMENTWISE_SEQ_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    // Write tracking depth: one cycle of buffer read latency plus the array latency.
    localparam int PD = EW_LAT + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [3:0]    func_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cnt;
    logic [AW-1:0] cnt_a;
    logic          accept;
    logic          last_issue;
    logic          drain_end;
    logic [PD-1:0] wr_vld;
    logic [AW-1:0] wr_addr [PD];

    assign accept     = cmd_valid && cmd_ready;
    assign cnt_a      = AW'(cnt);
    assign last_issue = (state == RUN) && (cnt == len_q - LW'(1));
    // In DRAIN no new reads enter, so the last write is the one with nothing behind it.
    assign drain_end  = wr_vld[PD-1] && (wr_vld[PD-2:0] == '0);

    // Next-state selection for the command FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (cmd_len == '0) ? DONE : RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched command fields and the read issue counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            func_q <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                func_q <= cmd_func;
                src_q  <= cmd_src;
                dst_q  <= cmd_dst;
                len_q  <= cmd_len;
                cnt    <= '0;
            end else if ((state == RUN) && !last_issue) begin
                cnt <= cnt + LW'(1);
            end
        end
    end

    // Valid/address shift pipeline that turns each read into its delayed write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_vld <= '0;
            for (int i = 0; i < PD; i++) wr_addr[i] <= '0;
        end else begin
            wr_vld     <= {wr_vld[PD-2:0], buf_rd_en};
            wr_addr[0] <= dst_q + cnt_a;
            for (int i = 1; i < PD; i++) wr_addr[i] <= wr_addr[i-1];
        end
    end

`ifdef ELEMENTWISE_SEQ_PERF_EN
    // Busy-cycle counter of the latest command, cleared at accept and saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign ew_en       = busy;
    assign ew_func     = (state == IDLE) ? 4'd0 : func_q;
    assign done        = (state == DONE);
    assign buf_rd_en   = (state == RUN);
    assign buf_rd_addr = buf_rd_en ? (src_q + cnt_a) : '0;
    assign buf_wr_en   = wr_vld[PD-1];
    assign buf_wr_addr = buf_wr_en ? wr_addr[PD-1] : '0;

endmodule

// File: tb/tb_elementwise_seq.sv
// tb_elementwise_seq: scoreboard bench for elementwise_seq.
// Expected reads/writes are queued at accept and popped as strobes appear; status is checked every cycle.
// Cycle n is the interval after the n-th rising clock edge; sampling happens on the falling edge.
module tb_elementwise_seq;

    localparam int AW     = 8;
    localparam int LW     = 8;
    localparam int EW_LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_func = '0;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic          ew_en;
    logic [3:0]    ew_func;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic          busy;
    logic          done;
`ifdef ELEMENTWISE_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    elementwise_seq #(.AW(AW), .LW(LW), .EW_LAT(EW_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_func    (cmd_func),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .ew_en       (ew_en),
        .ew_func     (ew_func),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .busy        (busy),
        .done        (done)
`ifdef ELEMENTWISE_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
    } ev_t;

    ev_t        rdq[$];
    ev_t        wrq[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         e_acc = -100;
    int         e_hi = -100;
    int         e_done = -100;
    int         e_perf = 0;
    logic [3:0] e_func = '0;
    int         last_acc = 0;
    bit         inplace_chk = 1'b0;
    bit         seen [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle monitor: status windows plus scoreboard pops.
    always @(negedge clk) begin
        ev_t e;
        bit  in_busy;
        bit  in_cmd;
        in_busy = (cyc > e_acc) && (cyc <= e_hi);
        in_cmd  = (cyc > e_acc) && (cyc <= e_done);
        check("busy", busy, in_busy);
        check("ew_en", ew_en, in_busy);
        check("done", done, cyc == e_done);
        check("cmd_ready", cmd_ready, !in_cmd);
        check("ew_func", ew_func, in_cmd ? e_func : 4'd0);
`ifdef ELEMENTWISE_SEQ_PERF_EN
        if (cyc == e_done) check("perf_cycles", perf_cycles, e_perf);
`endif
        if (buf_wr_en) begin
            if (wrq.size() == 0) begin
                check("wr_extra", 1, 0);
            end else begin
                e = wrq.pop_front();
                check("wr_addr", buf_wr_addr, e.addr);
                check("wr_cyc", cyc, e.cyc);
            end
            if (inplace_chk) check("inplace_order", seen[buf_wr_addr], 1);
        end
        if (buf_rd_en) begin
            if (rdq.size() == 0) begin
                check("rd_extra", 1, 0);
            end else begin
                e = rdq.pop_front();
                check("rd_addr", buf_rd_addr, e.addr);
                check("rd_cyc", cyc, e.cyc);
            end
            seen[buf_rd_addr] = 1'b1;
        end
    end

    // Drive a command (called on a falling edge), wait for acceptance, queue its expectations.
    task automatic send_cmd(input logic [3:0] f, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l);
        ev_t e;
        int  n;
        cmd_valid = 1'b1;
        cmd_func  = f;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_len   = l;
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        for (int i = 0; i < int'(l); i++) begin
            e.cyc  = cyc + 1 + i;
            e.addr = s + 8'(i);
            rdq.push_back(e);
            e.cyc  = cyc + 2 + EW_LAT + i;
            e.addr = d + 8'(i);
            wrq.push_back(e);
        end
        e_func = f;
        e_acc  = cyc;
        if (l == 0) begin
            e_hi   = cyc;
            e_done = cyc + 1;
            e_perf = 0;
        end else begin
            e_hi   = cyc + int'(l) + 1 + EW_LAT;
            e_done = e_hi + 1;
            e_perf = int'(l) + 1 + EW_LAT;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Advance until the command's done cycle and one idle cycle have been observed.
    task automatic wait_idle();
        while (cyc <= e_done + 1) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         prev_done;
        logic [7:0] rs;
        logic [7:0] rd;
        logic [7:0] rl;
        foreach (seen[k]) seen[k] = 1'b0;

        // Reset values.
        #1 reset = 1'b1;
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rd_en", buf_rd_en, 0);
        check("rst_rd_addr", buf_rd_addr, 0);
        check("rst_wr_en", buf_wr_en, 0);
        check("rst_wr_addr", buf_wr_addr, 0);
        check("rst_ew_en", ew_en, 0);
        check("rst_ew_func", ew_func, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef ELEMENTWISE_SEQ_PERF_EN
        check("rst_perf", perf_cycles, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic command.
        @(negedge clk);
        send_cmd(4'd3, 8'h10, 8'h20, 8'd4);
        wait_idle();

        // Zero-length command.
        send_cmd(4'd5, 8'h33, 8'h44, 8'd0);
        wait_idle();

        // Address wrap.
        send_cmd(4'd1, 8'hFE, 8'hFF, 8'd3);
        wait_idle();

        // Back-pressure: keep a decoy command valid while busy, then swap in the real one.
        send_cmd(4'd2, 8'h50, 8'h60, 8'd5);
        prev_done = e_done;
        cmd_valid = 1'b1;
        cmd_func  = 4'hF;
        cmd_src   = 8'hAA;
        cmd_dst   = 8'hBB;
        cmd_len   = 8'd9;
        repeat (3) @(negedge clk);
        send_cmd(4'd6, 8'h70, 8'h80, 8'd2);
        check("bp_accept_cyc", last_acc, prev_done + 1);
        wait_idle();

        // Reset in cycle 3 of a basic command.
        send_cmd(4'd3, 8'h10, 8'h20, 8'd4);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        rdq.delete();
        wrq.delete();
        e_acc  = -100;
        e_hi   = -100;
        e_done = -100;
        #1;
        check("abort_rd_en", buf_rd_en, 0);
        check("abort_wr_en", buf_wr_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ew_en", ew_en, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        @(negedge clk);
        send_cmd(4'd4, 8'h05, 8'h06, 8'd1);
        wait_idle();

        // In-place operation.
        foreach (seen[k]) seen[k] = 1'b0;
        inplace_chk = 1'b1;
        send_cmd(4'd7, 8'h40, 8'h40, 8'd8);
        wait_idle();
        inplace_chk = 1'b0;

        // Maximum length.
        send_cmd(4'd9, 8'h00, 8'h80, 8'hFF);
        wait_idle();

        // A few random commands.
        for (int t = 0; t < 6; t++) begin
            rs = 8'($urandom);
            rd = 8'($urandom);
            rl = 8'($urandom_range(0, 12));
            send_cmd(4'($urandom), rs, rd, rl);
            wait_idle();
        end

        check("rdq_empty", rdq.size(), 0);
        check("wrq_empty", wrq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
